hps_pio_mailbox_responder: RTL and testbench
============================================

// Module: hps_pio_mailbox_responder
// PURPOSE
//  FPGA-side responder for the HPS<->fabric PIO mailbox. Decodes 32-bit command words the HPS
//  writes on the pio_outputfromhps export (toggle handshake), runs them against a local operand
//  buffer and the NN core control, and returns a response word on the pio_inputfromfpga export.
//  Sits in the top level between soc_system and the NN core; all logic runs on clk_clk.
// PARAMETERS
//  DEPTH   16  operand buffer words (power of 2, 2..16); ADDR_W = $clog2(DEPTH)
//  DATA_W  16  operand/result width (<=16)
// PORTS
//  clk_clk        in   1   system clock (same clock as soc_system PIOs)
//  reset_reset    in   1   asynchronous, active-high reset
//  hps_cmd        in   32  from pio_outputfromhps_external_connection_export
//  hps_resp       out  32  to pio_inputfromfpga_external_connection_export
//  core_start     out  1   one-cycle start pulse to NN core
//  core_done      in   1   one-cycle completion pulse from NN core
//  core_result    in   DATA_W  result, valid when core_done=1
//  core_rd_addr   in   ADDR_W  core read address into operand buffer
//  core_rd_data   out  DATA_W  buffer data, 1-cycle read latency
// BEHAVIOUR
//  Command: [31] TOG, [30:28] OP, [27:24] ADDR, [15:0] DATA (low DATA_W bits used), rest ignored.
//  OP: 0 NOP, 1 WRITE buf[ADDR]=DATA, 2 READ buf[ADDR], 3 START core, 4 STATUS; 5-7 illegal.
//  Response: [31] ACK_TOG, [30:28] OP echo, [27] BUSY, [26] ERR, [25:16]=0, [15:0] data (zero-ext).
//  hps_cmd registered into cmd_q every cycle. Command accepted when cmd_q[31] != last_tog.
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//   IDLE: on toggle mismatch capture OP/ADDR/DATA/TOG, last_tog<=TOG, go EXEC.
//   EXEC: WRITE does RAM write; READ issues RAM read; START checks busy; go RESP.
//   RESP: hps_resp <= {TOG,OP,busy,err,10'b0,data}; go IDLE.
//  Latency: hps_resp updates on the 3rd clk edge after cmd_q captures a new toggle.
//  Response holds until the next command completes; HPS polls ACK_TOG==TOG.
//  READ data = buf[ADDR]; STATUS data = result_q; WRITE/START/NOP data = 0.
//  START: if !busy -> core_start pulse in EXEC cycle, busy<=1, ERR=0; if busy -> ERR=1, no pulse.
//  core_done (any state): result_q<=core_result, busy<=0. Same-cycle core_done and START in EXEC:
//   done applied first, START accepted (new pulse, busy stays 1, result_q updated).
//  ADDR >= DEPTH on READ/WRITE: ERR=1, no write, data=0. Illegal OP: ERR=1, data=0.
//  BUSY bit in response = busy as of the RESP edge input (post-EXEC value).
//  Toggle change arriving while in EXEC/RESP: detected in next IDLE cycle (never lost,
//   intermediate commands overwritten by HPS are not queued; HPS must wait for ack).
//  Reset: hps_resp=0, core_start=0, busy=0, result_q=0, state=IDLE, primed=0. First cycle after
//   reset copies cmd_q[31] into last_tog and sets primed without executing, so a command still
//   held on the PIO across reset is not re-run. Reset mid-operation aborts with no response.
//  Buffer contents not reset. core_rd_data reads the RAM port B independent of the FSM;
//   same-address WRITE/core read collision returns old data.
// STRUCTURE
//  hps_mbox_pkg: OP_* enum, command/response bit-position localparams, FSM state enum.
//  Sub-module mbox_buf_ram: simple dual-port RAM (port A write/read for FSM, port B read for core),
//   1-cycle registered reads, no reset.
// TESTING
//  1 Reset with hps_cmd=0x8000_0000 held -> no execution, hps_resp stays 0x0000_0000.
//  2 WRITE 0x9305_ABCD (TOG1,OP1,ADDR3) then READ 0x2300_0000 (TOG0,OP2,ADDR3) ->
//    resp 0x9000_0000 then 0x2000_ABCD; core_rd_addr=3 -> core_rd_data=0xABCD.
//  3 START 0xB000_0000 -> one core_start pulse, resp 0xB800_0000; second START before done ->
//    resp ERR: 0x3C00_0000, no pulse; core_done with result 0x1234 -> STATUS resp data 0x1234, BUSY=0.
//  4 WRITE ADDR=15 with DEPTH=8 -> ERR=1, buffer unchanged; OP=6 -> resp [26]=1, data 0.
//  5 core_done coincident with accepted START in EXEC -> core_start pulses, BUSY=1, result_q updated.
//  6 Assert reset_reset during EXEC -> hps_resp=0 immediately, no write, no core_start after release.

Source files
------------

// File: rtl/hps_mbox_pkg.sv
// Shared types for the HPS PIO mailbox responder.
// Command/response field positions, opcodes and FSM states.
package hps_mbox_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_WRITE  = 3'd1,
    OP_READ   = 3'd2,
    OP_START  = 3'd3,
    OP_STATUS = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  localparam int CMD_TOG     = 31;
  localparam int CMD_OP_HI   = 30;
  localparam int CMD_OP_LO   = 28;
  localparam int CMD_ADDR_HI = 27;
  localparam int CMD_ADDR_LO = 24;

endpackage

// File: rtl/mbox_buf_ram.sv
// Operand buffer: port A read/write for the mailbox FSM,
// port B read-only for the NN core. Registered reads, no reset.
module mbox_buf_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Same-address write/read returns the old word.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/hps_pio_mailbox_responder.sv
// FPGA-side responder for the HPS<->fabric PIO mailbox.
// Toggle-handshaked commands run against the operand buffer and NN core.
module hps_pio_mailbox_responder
  import hps_mbox_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [31:0]       hps_cmd,
  output logic [31:0]       hps_resp,
  output logic              core_start,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  input  logic [ADDR_W-1:0] core_rd_addr,
  output logic [DATA_W-1:0] core_rd_data
);

  logic [31:0]       cmd_q;
  logic              last_tog;
  logic              primed;
  state_e            state_q;
  state_e            state_d;
  logic              tog_q;
  logic [2:0]        op_q;
  logic [3:0]        addr_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              busy_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] a_rdata;
  logic              accept;
  logic              addr_bad;
  logic              start_ok;
  logic              ram_we;
  logic              exec_err;
  logic [15:0]       resp_data;
  logic              unused_cmd;

  // Not reset: keeps sampling during reset so priming sees the held toggle.
  always_ff @(posedge clk_clk) cmd_q <= hps_cmd;

  assign unused_cmd = ^cmd_q[23:0];
  assign accept     = primed && (cmd_q[CMD_TOG] != last_tog);
  assign addr_bad   = {28'b0, addr_q} >= DEPTH[31:0];
  assign core_start = start_ok;

  always_comb begin
    state_d  = state_q;
    ram_we   = 1'b0;
    start_ok = 1'b0;
    exec_err = 1'b0;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_RESP;
        unique case (1'b1)
          op_q == OP_NOP,
          op_q == OP_STATUS: ;
          op_q == OP_WRITE: begin
            exec_err = addr_bad;
            ram_we   = !addr_bad;
          end
          op_q == OP_READ: exec_err = addr_bad;
          op_q == OP_START: begin
            // A done in this same cycle frees the core first.
            start_ok = !busy_q || core_done;
            exec_err = !start_ok;
          end
          default: exec_err = 1'b1;
        endcase
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    resp_data = '0;
    unique case (1'b1)
      op_q == OP_READ && !err_q: resp_data[DATA_W-1:0] = a_rdata;
      op_q == OP_STATUS:         resp_data[DATA_W-1:0] = result_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q  <= ST_IDLE;
      primed   <= 1'b0;
      last_tog <= 1'b0;
      tog_q    <= 1'b0;
      op_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      hps_resp <= '0;
    end else begin
      state_q <= state_d;
      if (!primed) begin
        primed   <= 1'b1;
        last_tog <= cmd_q[CMD_TOG];
      end
      if (state_q == ST_IDLE && accept) begin
        last_tog <= cmd_q[CMD_TOG];
        tog_q    <= cmd_q[CMD_TOG];
        op_q     <= cmd_q[CMD_OP_HI:CMD_OP_LO];
        addr_q   <= cmd_q[CMD_ADDR_HI:CMD_ADDR_LO];
        data_q   <= cmd_q[DATA_W-1:0];
      end
      if (state_q == ST_EXEC) err_q <= exec_err;
      if (start_ok) busy_q <= 1'b1;
      else if (core_done) busy_q <= 1'b0;
      if (core_done) result_q <= core_result;
      if (state_q == ST_RESP)
        hps_resp <= {tog_q, op_q, busy_q, err_q, 10'b0, resp_data};
    end
  end

  mbox_buf_ram #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk    (clk_clk),
    .a_we   (ram_we),
    .a_addr (addr_q[ADDR_W-1:0]),
    .a_wdata(data_q),
    .a_rdata(a_rdata),
    .b_addr (core_rd_addr),
    .b_rdata(core_rd_data)
  );

endmodule

// File: tb/tb_hps_pio_mailbox_responder.sv
// Bench for the PIO mailbox responder (DEPTH=8).
// Spec-level model of buffer/busy/result, compared every cycle.
module tb_hps_pio_mailbox_responder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hps_cmd;
  logic [31:0] hps_resp;
  logic        core_start;
  logic        core_done;
  logic [15:0] core_result;
  logic [2:0]  core_rd_addr;
  logic [15:0] core_rd_data;

  int checks = 0;
  int passes = 0;

  logic [31:0] exp_resp  = 32'h0;
  logic        exp_start = 1'b0;
  logic [15:0] m_buf [16];
  logic        m_busy   = 1'b0;
  logic [15:0] m_result = 16'h0;

  always #5 clk = ~clk;

  hps_pio_mailbox_responder #(
    .DEPTH (DEPTH),
    .DATA_W(16)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .hps_cmd     (hps_cmd),
    .hps_resp    (hps_resp),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result),
    .core_rd_addr(core_rd_addr),
    .core_rd_data(core_rd_data)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    check("resp_cycle", hps_resp, exp_resp);
    check("start_cycle", {31'b0, core_start}, {31'b0, exp_start});
  end

  task automatic do_cmd(input logic [31:0] cmd, input bit done_exec = 0,
                        input logic [15:0] done_res = 16'h0);
    logic [2:0]  op;
    int          a;
    logic        err;
    logic [15:0] rd;
    op  = cmd[30:28];
    a   = int'(cmd[27:24]);
    err = 1'b0;
    rd  = 16'h0;
    @(negedge clk);
    hps_cmd = cmd;
    @(posedge clk);
    @(posedge clk);
    #1;
    if (done_exec) begin
      core_done   = 1'b1;
      core_result = done_res;
    end
    exp_start = (op == 3'd3) && (!m_busy || done_exec);
    @(posedge clk);
    #1;
    core_done = 1'b0;
    exp_start = 1'b0;
    if (done_exec) begin
      m_result = done_res;
      m_busy   = 1'b0;
    end
    case (op)
      3'd0: ;
      3'd1: if (a < DEPTH) m_buf[a] = cmd[15:0]; else err = 1'b1;
      3'd2: if (a < DEPTH) rd = m_buf[a]; else err = 1'b1;
      3'd3: if (m_busy) err = 1'b1; else m_busy = 1'b1;
      3'd4: rd = m_result;
      default: err = 1'b1;
    endcase
    @(posedge clk);
    #1;
    exp_resp = {cmd[31], op, m_busy, err, 10'b0, rd};
    @(negedge clk);
  endtask

  task automatic pulse_done(input logic [15:0] res);
    @(posedge clk);
    #1;
    core_done   = 1'b1;
    core_result = res;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    m_busy    = 1'b0;
    m_result  = res;
  endtask

  task automatic rd_core(input logic [2:0] a, input logic [15:0] exp);
    @(negedge clk);
    core_rd_addr = a;
    @(negedge clk);
    check("core_rd", {16'h0, core_rd_data}, {16'h0, exp});
  endtask

  initial begin
    rst          = 1'b1;
    hps_cmd      = 32'h8000_0000;
    core_done    = 1'b0;
    core_result  = 16'h0;
    core_rd_addr = 3'd0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("reset_hold", hps_resp, 32'h0);

    do_cmd(32'h0000_0000);
    check("nop", hps_resp, 32'h0000_0000);
    do_cmd(32'h9305_ABCD);
    check("write3", hps_resp, 32'h9000_0000);
    do_cmd(32'h2300_0000);
    check("read3", hps_resp, 32'h2000_ABCD);
    rd_core(3'd3, 16'hABCD);

    do_cmd(32'hB000_0000);
    check("start", hps_resp, 32'hB800_0000);
    do_cmd(32'h3000_0000);
    check("start_busy", hps_resp, 32'h3C00_0000);
    pulse_done(16'h1234);
    do_cmd(32'hC000_0000);
    check("status", hps_resp, 32'hC000_1234);

    do_cmd(32'h1700_5555);
    check("write7", hps_resp, 32'h1000_0000);
    do_cmd(32'h9F00_AAAA);
    check("write15", hps_resp, 32'h9400_0000);
    do_cmd(32'h2700_0000);
    check("read7", hps_resp, 32'h2000_5555);
    do_cmd(32'hAF00_0000);
    check("read15", hps_resp, 32'hA400_0000);
    do_cmd(32'h6000_0000);
    check("illegal", hps_resp, 32'h6400_0000);
    rd_core(3'd7, 16'h5555);

    do_cmd(32'hB000_0000);
    check("start2", hps_resp, 32'hB800_0000);
    do_cmd(32'h3000_0000, 1'b1, 16'h0777);
    check("start_done", hps_resp, 32'h3800_0000);
    do_cmd(32'hC000_0000);
    check("status2", hps_resp, 32'hC800_0777);
    pulse_done(16'h0042);

    do_cmd(32'h1200_1111);
    check("write2", hps_resp, 32'h1000_0000);
    @(negedge clk);
    hps_cmd = 32'h9200_2222;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    exp_resp  = 32'h0;
    m_busy    = 1'b0;
    m_result  = 16'h0;
    #1;
    check("reset_exec", hps_resp, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("reset_norun", hps_resp, 32'h0);
    rd_core(3'd2, 16'h1111);
    do_cmd(32'h2200_0000);
    check("read2", hps_resp, 32'h2000_1111);
    do_cmd(32'hC000_0000);
    check("status_rst", hps_resp, 32'hC000_0000);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
